// File: rtl/bit_deserializer.sv
// rtl/bit_deserializer.sv - serial-to-parallel packer with one-entry valid/ready output holding register
// Optional even-parity framing is enabled by defining BIT_DESERIALIZER_PARITY_EN.
module bit_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         din,
    input  logic                         din_valid,
    input  logic                         clr,
    output logic [WIDTH-1:0]             word_out,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic                         overflow,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
    output logic                         parity_err
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] frame_word;
    logic             frame_done;
    logic             frame_par;
    logic             data_bit;
    logic             load;
    logic             transfer;

`ifdef BIT_DESERIALIZER_PARITY_EN
    // Frame is WIDTH data bits plus a trailing even-parity bit that is not shifted in.
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
    assign data_bit   = (bit_cnt != LAST_CNT);
    assign frame_word = shift_reg;
    assign frame_par  = (^shift_reg) ^ din;
`else
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    assign data_bit   = 1'b1;
    assign frame_word = shift_next;
    assign frame_par  = 1'b0;
`endif

    assign shift_next = MSB_FIRST ? {shift_reg[WIDTH-2:0], din}
                                  : {din, shift_reg[WIDTH-1:1]};

    assign frame_done = din_valid && !clr && (bit_cnt == LAST_CNT);
    assign word_valid = (state == ST_FULL);
    assign transfer   = word_valid && word_ready;
    // A slot frees up in the same cycle the consumer drains the holding register.
    assign load       = frame_done && (!word_valid || word_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (clr) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (din_valid) begin
            if (frame_done) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else begin
                bit_cnt <= bit_cnt + CW'(1);
                if (data_bit) begin
                    shift_reg <= shift_next;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_EMPTY;
            word_out   <= '0;
            overflow   <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            overflow <= frame_done && !load;
            if (load) begin
                word_out   <= frame_word;
                parity_err <= frame_par;
                state      <= ST_FULL;
            end else if (transfer) begin
                state <= ST_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_bit_deserializer.sv
// tb/tb_bit_deserializer.sv - directed self-checking bench for bit_deserializer (MSB-first and LSB-first instances)
module tb_bit_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       clr = 1'b0;
    logic       word_ready = 1'b0;

    logic [7:0] m_word;
    logic       m_valid;
    logic       m_ovf;
    logic [3:0] m_cnt;
    logic       m_perr;

    logic [7:0] l_word;
    logic       l_valid;
    logic       l_ovf;
    logic [3:0] l_cnt;
    logic       l_perr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
        .word_out(m_word), .word_valid(m_valid), .word_ready(word_ready),
        .overflow(m_ovf), .bit_cnt(m_cnt), .parity_err(m_perr)
    );

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
        .word_out(l_word), .word_valid(l_valid), .word_ready(word_ready),
        .overflow(l_ovf), .bit_cnt(l_cnt), .parity_err(l_perr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        din       = b;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    // Sends the top n bits of v, v[7] first.
    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[7-i]);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        chk("reset_word", 32'(m_word), 32'h0);
        chk("reset_valid", 32'(m_valid), 32'h0);
        chk("reset_ovf", 32'(m_ovf), 32'h0);
        chk("reset_cnt", 32'(m_cnt), 32'h0);
        chk("reset_perr", 32'(m_perr), 32'h0);
        rst = 1'b0;
        step();
    endtask

    task automatic test_msb_first();
        word_ready = 1'b1;
        send_bits(8'hA5, 3);
        chk("msb_partial_cnt", 32'(m_cnt), 32'd3);
        chk("msb_partial_valid", 32'(m_valid), 32'h0);
        send_bits(8'hA5 << 3, 5);
        chk("msb_word", 32'(m_word), 32'hA5);
        chk("msb_valid", 32'(m_valid), 32'h1);
        chk("msb_ovf", 32'(m_ovf), 32'h0);
        chk("msb_cnt_wrap", 32'(m_cnt), 32'h0);
        chk("lsb_palindrome", 32'(l_word), 32'hA5);
        step();
        chk("msb_valid_drop", 32'(m_valid), 32'h0);
    endtask

    task automatic test_lsb_first();
        word_ready = 1'b1;
        send_bits(8'hC0, 8);
        chk("lsb_word_03", 32'(l_word), 32'h03);
        chk("lsb_valid", 32'(l_valid), 32'h1);
        chk("msb_word_c0", 32'(m_word), 32'hC0);
        step();
        chk("lsb_valid_drop", 32'(l_valid), 32'h0);
    endtask

    task automatic test_overflow();
        word_ready = 1'b0;
        send_bits(8'hA5, 8);
        chk("ovf_first_valid", 32'(m_valid), 32'h1);
        send_bits(8'h3C, 7);
        chk("ovf_not_early", 32'(m_ovf), 32'h0);
        send_bits(8'h3C << 7, 1);
        chk("ovf_pulse", 32'(m_ovf), 32'h1);
        chk("ovf_word_held", 32'(m_word), 32'hA5);
        chk("ovf_valid_held", 32'(m_valid), 32'h1);
        chk("ovf_cnt_wrap", 32'(m_cnt), 32'h0);
        step();
        chk("ovf_one_cycle", 32'(m_ovf), 32'h0);
        chk("ovf_word_stable", 32'(m_word), 32'hA5);
        word_ready = 1'b1;
        step();
        chk("ovf_drain_valid", 32'(m_valid), 32'h0);
        word_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        word_ready = 1'b0;
        send_bits(8'hA5, 8);
        send_bits(8'h3C, 7);
        word_ready = 1'b1;
        send_bits(8'h3C << 7, 1);
        chk("b2b_word", 32'(m_word), 32'h3C);
        chk("b2b_valid", 32'(m_valid), 32'h1);
        chk("b2b_ovf", 32'(m_ovf), 32'h0);
        step();
        chk("b2b_drain", 32'(m_valid), 32'h0);
        word_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        word_ready = 1'b0;
        send_bits(8'hA5, 8);
        send_bits(8'hFF, 5);
        chk("ar_cnt_before", 32'(m_cnt), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_cnt", 32'(m_cnt), 32'h0);
        chk("ar_word", 32'(m_word), 32'h0);
        chk("ar_valid", 32'(m_valid), 32'h0);
        #1;
        rst = 1'b0;
        step();
        send_bits(8'h3C, 8);
        chk("ar_word_3c", 32'(m_word), 32'h3C);
        chk("ar_valid_3c", 32'(m_valid), 32'h1);
        word_ready = 1'b1;
        step();
        word_ready = 1'b0;
    endtask

    task automatic test_clr();
        word_ready = 1'b0;
        send_bits(8'hA5, 8);
        send_bits(8'hFF, 5);
        clr       = 1'b1;
        din       = 1'b1;
        din_valid = 1'b1;
        step();
        clr       = 1'b0;
        din_valid = 1'b0;
        chk("clr_cnt", 32'(m_cnt), 32'h0);
        chk("clr_word_kept", 32'(m_word), 32'hA5);
        chk("clr_valid_kept", 32'(m_valid), 32'h1);
        word_ready = 1'b1;
        step();
        word_ready = 1'b0;
        send_bits(8'h3C, 8);
        chk("clr_word_3c", 32'(m_word), 32'h3C);
        chk("clr_ovf", 32'(m_ovf), 32'h0);
        word_ready = 1'b1;
        step();
        word_ready = 1'b0;
    endtask

    task automatic test_parity();
        word_ready = 1'b1;
`ifdef BIT_DESERIALIZER_PARITY_EN
        send_bits(8'hA5, 8);
        chk("par_wait_valid", 32'(m_valid), 32'h0);
        chk("par_wait_cnt", 32'(m_cnt), 32'd8);
        send_bit(1'b0);
        chk("par_good_word", 32'(m_word), 32'hA5);
        chk("par_good_valid", 32'(m_valid), 32'h1);
        chk("par_good_err", 32'(m_perr), 32'h0);
        step();
        send_bits(8'hA5, 8);
        send_bit(1'b1);
        chk("par_bad_err", 32'(m_perr), 32'h1);
        chk("par_bad_word", 32'(m_word), 32'hA5);
        step();
`else
        send_bits(8'hA5, 8);
        chk("nopar_word", 32'(m_word), 32'hA5);
        chk("nopar_err", 32'(m_perr), 32'h0);
        send_bit(1'b1);
        chk("nopar_new_word_cnt", 32'(m_cnt), 32'd1);
        chk("nopar_err_after", 32'(m_perr), 32'h0);
        clr = 1'b1;
        step();
        clr = 1'b0;
`endif
        word_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        test_clr();
        test_parity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
